writeback_regfile: RTL and testbench

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

---
 rtl/riscv_pkg.sv | 18 +
 rtl/wb_mux.sv | 24 ++
 rtl/writeback_regfile.sv | 76 +++++++
 tb/tb_writeback_regfile.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the writeback / register file slice.
//   NUM_REGS  - architectural integer register count
//   XLEN      - default datapath width
//   reg_idx_t - register index type
//   wb_sel_e  - writeback source select encoding
package riscv_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned XLEN     = 64;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_sel_e;

endpackage

// File: rtl/wb_mux.sv
// wb_mux: combinational writeback source select.
//   mem_to_reg  : 1 = data_mem (load), 0 = address_mem (ALU result)
//   address_mem : ALU result from the MEM stage
//   data_mem    : load data
//   write_data  : selected writeback value
module wb_mux
  import riscv_pkg::*;
#(
  parameter int unsigned N = XLEN
) (
  input  logic         mem_to_reg,
  input  logic [N-1:0] address_mem,
  input  logic [N-1:0] data_mem,
  output logic [N-1:0] write_data
);

  wb_sel_e sel;

  always_comb begin
    sel        = wb_sel_e'(mem_to_reg);
    write_data = (sel == WB_MEM) ? data_mem : address_mem;
  end

endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: writeback select plus 32 x N register file with two
// combinational read ports and a committed-write counter.
//   clk, rst            : clock, asynchronous active-high reset
//   memToReg            : writeback select (1 = dataMem, 0 = addressMem)
//   regWrite, writeReg  : write enable and destination index
//   addressMem, dataMem : writeback sources
//   readReg1/2          : read indices; readData1/2 : read data
//   writeData           : selected writeback value (for forwarding)
//   wbCount             : number of committed writes (wraps silently)
// Build option: define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module writeback_regfile
  import riscv_pkg::*;
#(
  parameter int unsigned N = XLEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         memToReg,
  input  logic         regWrite,
  input  logic [4:0]   writeReg,
  input  logic [N-1:0] addressMem,
  input  logic [N-1:0] dataMem,
  input  logic [4:0]   readReg1,
  input  logic [4:0]   readReg2,
  output logic [N-1:0] readData1,
  output logic [N-1:0] readData2,
  output logic [N-1:0] writeData,
  output logic [31:0]  wbCount
);

  logic [N-1:0] regs [NUM_REGS];
  logic [31:0]  wb_count;
  logic         commit;
  reg_idx_t     wr_idx;
  reg_idx_t     rd_idx1;
  reg_idx_t     rd_idx2;

  wb_mux #(.N(N)) u_wb_mux (
    .mem_to_reg  (memToReg),
    .address_mem (addressMem),
    .data_mem    (dataMem),
    .write_data  (writeData)
  );

  assign wr_idx  = writeReg;
  assign rd_idx1 = readReg1;
  assign rd_idx2 = readReg2;
  assign commit  = regWrite && (wr_idx != '0);
  assign wbCount = wb_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      wb_count <= '0;
    end else if (commit) begin
      regs[wr_idx] <= writeData;
      wb_count     <= wb_count + 32'd1;
    end
  end

  // Zero override is applied last so neither the bypass nor a stale
  // array entry can leak through for index 0 or while in reset.
  always_comb begin
    readData1 = regs[rd_idx1];
    readData2 = regs[rd_idx2];
`ifdef REGFILE_BYPASS_EN
    if (commit && (rd_idx1 == wr_idx)) readData1 = writeData;
    if (commit && (rd_idx2 == wr_idx)) readData2 = writeData;
`endif
    if (rst || (rd_idx1 == '0)) readData1 = '0;
    if (rst || (rd_idx2 == '0)) readData2 = '0;
  end

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

  localparam int unsigned N = 64;

  logic         clk;
  logic         rst;
  logic         memToReg;
  logic         regWrite;
  logic [4:0]   writeReg;
  logic [N-1:0] addressMem;
  logic [N-1:0] dataMem;
  logic [4:0]   readReg1;
  logic [4:0]   readReg2;
  logic [N-1:0] readData1;
  logic [N-1:0] readData2;
  logic [N-1:0] writeData;
  logic [31:0]  wbCount;

  int checks;
  int failures;
  logic [31:0] exp_count;

  writeback_regfile #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .memToReg   (memToReg),
    .regWrite   (regWrite),
    .writeReg   (writeReg),
    .addressMem (addressMem),
    .dataMem    (dataMem),
    .readReg1   (readReg1),
    .readReg2   (readReg2),
    .readData1  (readData1),
    .readData2  (readData2),
    .writeData  (writeData),
    .wbCount    (wbCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs after the falling edge, apply one rising edge, sample #1 later.
  task automatic do_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; memToReg = 1'b0; regWrite = 1'b1; writeReg = 5'd5;
    addressMem = 64'h99; dataMem = '0; readReg1 = 5'd5; readReg2 = 5'd0;
    #2;
    checks++;
    if (readData1 !== 64'd0) begin failures++; $display("FAIL reset_rd1 got=%h exp=%h", readData1, 64'd0); end
    checks++;
    if (wbCount !== 32'd0) begin failures++; $display("FAIL reset_count got=%h exp=%h", wbCount, 32'd0); end
    do_edge();
    checks++;
    if (wbCount !== 32'd0) begin failures++; $display("FAIL reset_write_ignored_count got=%h exp=%h", wbCount, 32'd0); end
    @(negedge clk);
    regWrite = 1'b0; rst = 1'b0;
    #1;
    checks++;
    if (readData1 !== 64'd0) begin failures++; $display("FAIL reset_write_ignored_x5 got=%h exp=%h", readData1, 64'd0); end
    exp_count = 32'd0;
  endtask

  task automatic test_write_alu();
    @(negedge clk);
    memToReg = 1'b0; regWrite = 1'b1; writeReg = 5'd5;
    addressMem = 64'h1234; dataMem = 64'hFFFF; readReg1 = 5'd5;
    #1;
    checks++;
    if (writeData !== 64'h1234) begin failures++; $display("FAIL alu_writedata got=%h exp=%h", writeData, 64'h1234); end
    do_edge();
    exp_count = exp_count + 32'd1;
    @(negedge clk); regWrite = 1'b0; #1;
    checks++;
    if (readData1 !== 64'h1234) begin failures++; $display("FAIL alu_x5 got=%h exp=%h", readData1, 64'h1234); end
    checks++;
    if (wbCount !== exp_count) begin failures++; $display("FAIL alu_count got=%h exp=%h", wbCount, exp_count); end
  endtask

  task automatic test_write_x0();
    @(negedge clk);
    memToReg = 1'b1; dataMem = 64'hDEADBEEF; addressMem = 64'h1; regWrite = 1'b1;
    writeReg = 5'd0; readReg1 = 5'd0; readReg2 = 5'd0;
    #1;
    checks++;
    if (writeData !== 64'hDEADBEEF) begin failures++; $display("FAIL x0_writedata got=%h exp=%h", writeData, 64'hDEADBEEF); end
    checks++;
    if (readData1 !== 64'd0) begin failures++; $display("FAIL x0_no_bypass got=%h exp=%h", readData1, 64'd0); end
    do_edge();
    @(negedge clk); regWrite = 1'b0; #1;
    checks++;
    if (readData2 !== 64'd0) begin failures++; $display("FAIL x0_read got=%h exp=%h", readData2, 64'd0); end
    checks++;
    if (wbCount !== exp_count) begin failures++; $display("FAIL x0_count got=%h exp=%h", wbCount, exp_count); end
  endtask

  task automatic test_bypass();
    logic [N-1:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 64'hAA;
`else
    exp_pre = 64'h0;
`endif
    @(negedge clk);
    memToReg = 1'b0; regWrite = 1'b1; writeReg = 5'd7; readReg2 = 5'd7;
    readReg1 = 5'd5; addressMem = 64'hAA;
    #1;
    checks++;
    if (readData2 !== exp_pre) begin failures++; $display("FAIL bypass_pre_rd2 got=%h exp=%h", readData2, exp_pre); end
    checks++;
    if (readData1 !== 64'h1234) begin failures++; $display("FAIL bypass_other_port got=%h exp=%h", readData1, 64'h1234); end
    do_edge();
    exp_count = exp_count + 32'd1;
    @(negedge clk); regWrite = 1'b0; #1;
    checks++;
    if (readData2 !== 64'hAA) begin failures++; $display("FAIL bypass_post_rd2 got=%h exp=%h", readData2, 64'hAA); end
    checks++;
    if (wbCount !== exp_count) begin failures++; $display("FAIL bypass_count got=%h exp=%h", wbCount, exp_count); end
  endtask

  task automatic test_no_write();
    @(negedge clk);
    regWrite = 1'b0; writeReg = 5'd9; addressMem = 64'hFF; memToReg = 1'b0;
    readReg1 = 5'd9; readReg2 = 5'd5;
    do_edge();
    checks++;
    if (readData1 !== 64'd0) begin failures++; $display("FAIL nowrite_x9 got=%h exp=%h", readData1, 64'd0); end
    checks++;
    if (readData2 !== 64'h1234) begin failures++; $display("FAIL nowrite_x5 got=%h exp=%h", readData2, 64'h1234); end
    checks++;
    if (wbCount !== exp_count) begin failures++; $display("FAIL nowrite_count got=%h exp=%h", wbCount, exp_count); end
  endtask

  task automatic test_reset_midcycle();
    @(negedge clk);
    memToReg = 1'b0; regWrite = 1'b1; writeReg = 5'd3; addressMem = 64'h55;
    do_edge();
    @(negedge clk);
    writeReg = 5'd4; addressMem = 64'h66;
    do_edge();
    exp_count = exp_count + 32'd2;
    @(negedge clk);
    regWrite = 1'b0; readReg1 = 5'd3; readReg2 = 5'd4;
    #1;
    checks++;
    if ((readData1 !== 64'h55) || (readData2 !== 64'h66)) begin
      failures++; $display("FAIL preload_x3_x4 got=%h,%h exp=%h,%h", readData1, readData2, 64'h55, 64'h66);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ((readData1 !== 64'd0) || (readData2 !== 64'd0)) begin
      failures++; $display("FAIL rst_async_regs got=%h,%h exp=0,0", readData1, readData2);
    end
    checks++;
    if (wbCount !== 32'd0) begin failures++; $display("FAIL rst_async_count got=%h exp=%h", wbCount, 32'd0); end
    // bypass condition present while in reset must still read zero
    regWrite = 1'b1; writeReg = 5'd3; addressMem = 64'h77;
    #1;
    checks++;
    if (readData1 !== 64'd0) begin failures++; $display("FAIL rst_no_bypass got=%h exp=%h", readData1, 64'd0); end
    do_edge();
    checks++;
    if (wbCount !== 32'd0) begin failures++; $display("FAIL rst_edge_write_lost got=%h exp=%h", wbCount, 32'd0); end
    @(negedge clk);
    rst = 1'b0;
    do_edge();
    exp_count = 32'd1;
    @(negedge clk); regWrite = 1'b0; #1;
    checks++;
    if (readData1 !== 64'h77) begin failures++; $display("FAIL post_rst_x3 got=%h exp=%h", readData1, 64'h77); end
    checks++;
    if (readData2 !== 64'd0) begin failures++; $display("FAIL post_rst_x4 got=%h exp=%h", readData2, 64'd0); end
    checks++;
    if (wbCount !== exp_count) begin failures++; $display("FAIL post_rst_count got=%h exp=%h", wbCount, exp_count); end
  endtask

  task automatic test_count_wrap();
    @(negedge clk);
    dut.wb_count = 32'hFFFF_FFFF;
    memToReg = 1'b0; regWrite = 1'b1; writeReg = 5'd0; addressMem = 64'h3;
    do_edge();
    checks++;
    if (wbCount !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_x0_hold got=%h exp=%h", wbCount, 32'hFFFF_FFFF); end
    @(negedge clk);
    writeReg = 5'd10; readReg1 = 5'd10;
    do_edge();
    exp_count = 32'd0;
    checks++;
    if (wbCount !== exp_count) begin failures++; $display("FAIL wrap_count got=%h exp=%h", wbCount, exp_count); end
    @(negedge clk); regWrite = 1'b0; #1;
    checks++;
    if (readData1 !== 64'h3) begin failures++; $display("FAIL wrap_x10 got=%h exp=%h", readData1, 64'h3); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] vals [3];
    vals[0] = 64'h1111_2222_3333_4444;
    vals[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    vals[2] = 64'h8000_0000_0000_0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      memToReg = 1'b1; regWrite = 1'b1; writeReg = 5'(20 + i);
      dataMem = vals[i]; addressMem = 64'hBAD;
      do_edge();
      exp_count = exp_count + 32'd1;
    end
    @(negedge clk);
    regWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      readReg1 = 5'(20 + i); readReg2 = 5'(20 + i);
      #1;
      checks++;
      if ((readData1 !== vals[i]) || (readData2 !== vals[i])) begin
        failures++; $display("FAIL b2b_x%0d got=%h,%h exp=%h", 20 + i, readData1, readData2, vals[i]);
      end
    end
    checks++;
    if (wbCount !== exp_count) begin failures++; $display("FAIL b2b_count got=%h exp=%h", wbCount, exp_count); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_count = '0;
    test_reset();
    test_write_alu();
    test_write_x0();
    test_bypass();
    test_no_write();
    test_reset_midcycle();
    test_count_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
